aes_inv_cipher_128: RTL and testbench
=====================================

// Module: aes_inv_cipher_128
// PURPOSE
//  Iterative AES-128 decryptor (FIPS-197 InvCipher), one round per clock; the receive-side counterpart of the AES-128 encryptor.
//  Expands the key once through aes_key_expand_128, stores all 11 round keys, then decrypts any number of blocks with that key.
//  Sits beside the encryptor in the crypto datapath and shares its key-load/ld/done conventions.
// PARAMETERS
//  NR        10   number of rounds (fixed for AES-128; not to be overridden)
//  NK_WORDS  4    key words per round key
// PORTS
//  clk        in   1    rising-edge clock, the only clock
//  rst_n      in   1    reset, asynchronous assert, active-low
//  kld        in   1    key load strobe; samples key
//  key        in   128  cipher key, FIPS byte order (key[127:120] = byte 0)
//  kdone      out  1    one-cycle pulse: round-key store complete
//  key_valid  out  1    level: stored keys usable; cleared by reset and by kld
//  ld         in   1    block load strobe; samples text_in
//  text_in    in   128  ciphertext, same byte order as key
//  busy       out  1    high from the edge sampling ld until done
//  done       out  1    one-cycle pulse: text_out newly valid
//  text_out   out  128  plaintext; held until next done
// BEHAVIOUR
//  Reset (rst_n=0, async): FSM=IDLE, kdone=0, key_valid=0, busy=0, done=0, text_out=0, counters=0. Round-key store is not reset.
//  FSM states: IDLE (no key) -> KEXP on kld; KEXP -> READY after rk10 is stored; READY -> RUN on ld; RUN -> READY after the final round.
//  Key phase: kld sampled at edge E0. The expander presents rk_i after edge E_i; rk_i is written to store[i] at E_(i+1).
//    kdone and key_valid are set at E11, so kdone goes high 11 cycles after kld.
//  Decrypt, with ld sampled at E0 (READY or RUN):
//    E0:      capture text_in.
//    E1:      state = text_in ^ rk10.
//    E2..E10: nine rounds. Each round is InvShiftRows, InvSubBytes, ^rk(r), InvMixColumns, with r = 9 down to 1.
//    E11:     text_out = InvSubBytes(InvShiftRows(state)) ^ rk0; done=1 for one cycle; busy=0.
//  Latency 11 cycles, ld to done. Throughput is 1 block per 11 cycles; ld may be applied in the cycle done is high.
//  InvMixColumns per column (GF(2^8), poly 0x11b, via xtime): out0 = 0e*s0 ^ 0b*s1 ^ 0d*s2 ^ 09*s3, rotated for out1..3.
//  InvShiftRows: row r rotates right by r bytes. State byte mapping matches the encryptor: column c = word c, row 0 = MSB.
//  Boundary conditions:
//    ld in IDLE or KEXP: ignored; no busy, no done.
//    ld while RUN: abort the current block with no done; restart from E0 with the new text_in.
//    kld in any state: key_valid=0, abort any RUN (no done), restart key expansion.
//    kld and ld in the same cycle: kld wins; ld is dropped.
//    rst_n low mid-operation: immediate clear; no done or kdone after release until a new kld/ld.
//    text_out changes only at done edges.
// STRUCTURE
//  Shared header aes_defs.vh: AES_NR=10, byte/word widths, the xtime macro/function, and 0x11b.
//  The encryptor migrates to the same header.
//  Sub-module aes_inv_sbox: combinational 8-bit inverse S-box, 16 instances.
//  Reuse aes_key_expand_128 unchanged.
//  Local functions: inv_mix_col, mul09/0b/0d/0e. Key store: 11x128 register array indexed by the round counter.
// TESTING
//  1. Reset, then pulse ld with no kld -> busy=0, done never asserts within 30 cycles, text_out=0.
//  2. kld key=000102030405060708090a0b0c0d0e0f -> kdone exactly 11 cycles later.
//     Then ld 69c4e0d86a7b0430d8cdb78070b4c55a -> done 11 cycles later, text_out=00112233445566778899aabbccddeeff.
//  3. kld key=2b7e151628aed2a6abf7158809cf4f3c, ld 3925841d02dc09fbdc118597196a0b32 -> text_out=3243f6a8885a308d313198a2e0370734.
//     A second ld on the done cycle with the same ciphertext gives a second done 11 cycles later with the same value.
//  4. ld at cycle 5 of a RUN with a new block -> no done for the first block; one done 11 cycles after the second ld with the correct plaintext.
//  5. kld during RUN, and a separate case with kld+ld in the same cycle -> no done, key_valid=0 until kdone.
//     A later ld decrypts correctly under the new key.
//  6. rst_n low at cycle 6 of RUN -> outputs 0 asynchronously; no done after release.
//     Additionally, 1000 random key/plaintext pairs through the encryptor then this block -> round trip equals the original.

Source files
------------

// File: rtl/aes_inv_cipher_128_pkg.sv
// rtl/aes_inv_cipher_128_pkg.sv - shared AES types, constants and GF(2^8) helpers
package aes_inv_cipher_128_pkg;

  localparam int NR       = 10;
  localparam int NK_WORDS = 4;
  localparam int BLK_W    = 128;
  localparam int WORD_W   = 32;
  // 0x11b with the x^8 term folded into the shift
  localparam logic [7:0] GF_POLY = 8'h1b;

  typedef logic [BLK_W-1:0]  blk_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {ST_IDLE, ST_KEXP, ST_READY, ST_RUN} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 via an addition chain; 0 maps to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    a252 = gf_mul(a240, a12);
    return gf_mul(a252, a2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input logic [2:0] n);
    return (a << n) | (a >> (4'd8 - {1'b0, n}));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 3'd1) ^ rotl8(b, 3'd2) ^ rotl8(b, 3'd3) ^ rotl8(b, 3'd4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    return gf_inv(rotl8(a, 3'd1) ^ rotl8(a, 3'd3) ^ rotl8(a, 3'd6) ^ 8'h05);
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox_fwd(w[31:24]), sbox_fwd(w[23:16]), sbox_fwd(w[15:8]), sbox_fwd(w[7:0])};
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  function automatic word_t inv_mix_col(input word_t w);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = w;
    return {mul0e(s0) ^ mul0b(s1) ^ mul0d(s2) ^ mul09(s3),
            mul09(s0) ^ mul0e(s1) ^ mul0b(s2) ^ mul0d(s3),
            mul0d(s0) ^ mul09(s1) ^ mul0e(s2) ^ mul0b(s3),
            mul0b(s0) ^ mul0d(s1) ^ mul09(s2) ^ mul0e(s3)};
  endfunction

  function automatic blk_t inv_mix_blk(input blk_t s);
    blk_t o;
    o = '0;
    for (int c = 0; c < NK_WORDS; c++)
      o[BLK_W-1-WORD_W*c -: WORD_W] = inv_mix_col(s[BLK_W-1-WORD_W*c -: WORD_W]);
    return o;
  endfunction

  // Byte (row r, column c) sits at index 4c+r, row 0 in the word MSB
  function automatic blk_t inv_shift_rows(input blk_t s);
    blk_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[BLK_W-1-8*(4*c+r) -: 8] = s[BLK_W-1-8*(4*(((c + 4) - r) % 4)+r) -: 8];
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// rtl/aes_inv_sbox.sv - combinational 8-bit AES inverse S-box
module aes_inv_sbox
  import aes_inv_cipher_128_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = sbox_inv(a);

endmodule

// File: rtl/aes_key_expand_128.sv
// rtl/aes_key_expand_128.sv - AES-128 key schedule, one round key per clock after kld
module aes_key_expand_128
  import aes_inv_cipher_128_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kld,
  input  logic [127:0] key,
  output logic [127:0] rk
);

  logic [7:0] rcon;
  word_t      w0, w1, w2, w3, t, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk;
  assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk   <= '0;
      rcon <= 8'h00;
    end else if (kld) begin
      rk   <= key;
      rcon <= 8'h01;
    end else begin
      rk   <= {n0, n1, n2, n3};
      rcon <= xtime(rcon);
    end
  end

endmodule

// File: rtl/aes_inv_cipher_128.sv
// rtl/aes_inv_cipher_128.sv - iterative AES-128 decryptor, one round per clock
module aes_inv_cipher_128
  import aes_inv_cipher_128_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kld,
  input  logic [127:0] key,
  output logic         kdone,
  output logic         key_valid,
  input  logic         ld,
  input  logic [127:0] text_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] text_out
);

  localparam logic [3:0] LAST = 4'(NR);

  state_t     state, state_nxt;
  logic [3:0] kcnt, step, rk_idx;
  logic       ld_ok;
  blk_t       rk, rk_sel, blk, isr, isb, ark, rnd_out;
  blk_t       key_store [0:NR];

  aes_key_expand_128 u_kexp (
    .clk   (clk),
    .rst_n (rst_n),
    .kld   (kld),
    .key   (key),
    .rk    (rk)
  );

  // Step 0 whitens with rk10, steps 1..10 walk rk9 down to rk0
  assign rk_idx  = LAST - step;
  assign rk_sel  = key_store[rk_idx];
  assign isr     = inv_shift_rows(blk);
  assign ark     = isb ^ rk_sel;
  assign rnd_out = (step == 4'd0) ? (blk ^ rk_sel) : inv_mix_blk(ark);
  assign ld_ok   = ld && !kld && (state == ST_READY || state == ST_RUN);

  for (genvar i = 0; i < 16; i++) begin : g_isb
    aes_inv_sbox u_isb (
      .a (isr[8*i +: 8]),
      .y (isb[8*i +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (kld) begin
      state_nxt = ST_KEXP;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_IDLE;
        ST_KEXP:  if (kcnt == LAST) state_nxt = ST_READY;
        ST_READY: if (ld) state_nxt = ST_RUN;
        ST_RUN:   if (!ld && step == LAST) state_nxt = ST_READY;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = 1'b0;
    key_valid = 1'b0;
    case (state)
      ST_READY: key_valid = 1'b1;
      ST_RUN: begin
        busy      = 1'b1;
        key_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Round keys are written straight from the expander; no reset needed
  always_ff @(posedge clk) begin
    if (state == ST_KEXP && !kld) key_store[kcnt] <= rk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kcnt     <= 4'd0;
      step     <= 4'd0;
      blk      <= '0;
      text_out <= '0;
      done     <= 1'b0;
      kdone    <= 1'b0;
    end else begin
      done  <= 1'b0;
      kdone <= 1'b0;
      if (kld) begin
        kcnt <= 4'd0;
      end else if (state == ST_KEXP) begin
        kcnt <= kcnt + 4'd1;
        if (kcnt == LAST) kdone <= 1'b1;
      end
      if (ld_ok) begin
        blk  <= text_in;
        step <= 4'd0;
      end else if (state == ST_RUN && !kld) begin
        if (step == LAST) begin
          text_out <= ark;
          done     <= 1'b1;
        end else begin
          blk  <= rnd_out;
          step <= step + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_128.sv
// tb/tb_aes_inv_cipher_128.sv - scoreboard bench for aes_inv_cipher_128 with an AES encrypt model
module tb_aes_inv_cipher_128;

  logic         clk = 1'b0;
  logic         rst_n, kld, ld;
  logic [127:0] key, text_in, text_out;
  logic         kdone, key_valid, busy, done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [127:0] pt;
    int           due;
  } exp_t;
  exp_t       exp_q[$];
  logic [7:0] sb [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_cipher_128 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .kld       (kld),
    .key       (key),
    .kdone     (kdone),
    .key_valid (key_valid),
    .ld        (ld),
    .text_in   (text_in),
    .busy      (busy),
    .done      (done),
    .text_out  (text_out)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_xt(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ a;
      a = m_xt(a);
    end
    return r;
  endfunction

  // Forward S-box from a brute-force inverse search plus the bitwise affine map
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 0;
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [31:0] tmp;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = m_xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int b = 0; b < 16; b++) t[b] = sb[s[b]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = m_xt(a0) ^ m_xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ m_xt(a1) ^ m_xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ m_xt(a2) ^ m_xt(a3) ^ a3;
          s[4*c+3] = m_xt(a0) ^ a0 ^ a1 ^ a2 ^ m_xt(a3);
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*rnd + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) o[127-8*b -: 8] = s[b];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // All driving tasks start and end just after a falling edge
  task automatic issue_ld(input logic [127:0] ct, input logic expect_done, input logic [127:0] pt);
    exp_t e;
    ld      = 1'b1;
    text_in = ct;
    if (expect_done) begin
      e.pt  = pt;
      e.due = cyc + 12;
      exp_q.push_back(e);
    end
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic issue_kld(input logic [127:0] k, input logic with_ld);
    int c;
    logic got;
    kld = 1'b1;
    key = k;
    if (with_ld) begin
      ld      = 1'b1;
      text_in = rnd128();
    end
    c = cyc;
    @(negedge clk);
    kld = 1'b0;
    ld  = 1'b0;
    check("key_valid_cleared", 128'(key_valid), 128'(0));
    check("busy_after_kld", 128'(busy), 128'(0));
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      if (kdone) got = 1'b1;
      else @(negedge clk);
    end
    check("kdone_seen", 128'(got), 128'(1));
    check("kdone_latency", 128'(cyc - c - 1), 128'(11));
    check("key_valid_set", 128'(key_valid), 128'(1));
  endtask

  task automatic wait_done(input int bound);
    logic got;
    got = 1'b0;
    for (int n = 0; n < bound && !got; n++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    check("done_seen", 128'(got), 128'(1));
  endtask

  task automatic drain(input int bound);
    for (int n = 0; n < bound && exp_q.size() > 0; n++) @(negedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 text_out=%h want no done", text_out);
        end else begin
          e = exp_q.pop_front();
          check("plaintext", text_out, e.pt);
          check("done_cycle", 128'(cyc), 128'(e.due));
          check("busy_at_done", 128'(busy), 128'(0));
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [127:0] k, pt, k2;
    build_sbox();
    rst_n = 1'b0; kld = 1'b0; ld = 1'b0; key = '0; text_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_kdone", 128'(kdone), 128'(0));
    check("rst_key_valid", 128'(key_valid), 128'(0));
    check("rst_text_out", text_out, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    issue_ld(rnd128(), 1'b0, '0);
    check("ld_no_key_busy", 128'(busy), 128'(0));
    repeat (30) @(negedge clk);
    check("ld_no_key_text_out", text_out, 128'(0));

    issue_kld(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    issue_ld(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, 128'h00112233445566778899aabbccddeeff);
    drain(20);

    k2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    issue_kld(k2, 1'b0);
    issue_ld(128'h3925841d02dc09fbdc118597196a0b32, 1'b1, 128'h3243f6a8885a308d313198a2e0370734);
    wait_done(20);
    issue_ld(128'h3925841d02dc09fbdc118597196a0b32, 1'b1, 128'h3243f6a8885a308d313198a2e0370734);
    drain(20);

    issue_ld(rnd128(), 1'b0, '0);
    repeat (4) @(negedge clk);
    pt = rnd128();
    issue_ld(aes_enc(k2, pt), 1'b1, pt);
    drain(20);

    issue_ld(rnd128(), 1'b0, '0);
    repeat (3) @(negedge clk);
    k = rnd128();
    issue_kld(k, 1'b0);
    pt = rnd128();
    issue_ld(aes_enc(k, pt), 1'b1, pt);
    drain(20);

    k = rnd128();
    issue_kld(k, 1'b1);
    pt = rnd128();
    issue_ld(aes_enc(k, pt), 1'b1, pt);
    drain(20);

    issue_ld(rnd128(), 1'b0, '0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 128'(busy), 128'(0));
    check("async_rst_done", 128'(done), 128'(0));
    check("async_rst_key_valid", 128'(key_valid), 128'(0));
    check("async_rst_text_out", text_out, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue_ld(rnd128(), 1'b0, '0);
    check("ld_after_rst_busy", 128'(busy), 128'(0));
    repeat (25) @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      k  = rnd128();
      pt = rnd128();
      issue_kld(k, 1'b0);
      issue_ld(aes_enc(k, pt), 1'b1, pt);
      drain(20);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
